// File: rtl/timebase_if.sv
// timebase_if: control and strobe bundle of the shared timebase.
// master drives en/clr, slave returns taps, ms_tick and cnt.
interface timebase_if #(
  parameter int WIDTH = 32,
  parameter int NTAPS = 6
);
  logic             en;
  logic             clr;
  logic [NTAPS-1:0] taps;
  logic             ms_tick;
  logic [WIDTH-1:0] cnt;

  modport master (
    output en, clr,
    input  taps, ms_tick, cnt
  );

  modport slave (
    input  en, clr,
    output taps, ms_tick, cnt
  );
endinterface

// File: rtl/timebase.sv
// timebase: free-running counter with binary tap strobes and a 1 ms tick.
// Ports: clk, rst_n (async low), bus (slave: en, clr -> taps, ms_tick, cnt).
module timebase #(
  parameter int CLK_HZ = 12_000_000,
  parameter int WIDTH  = 32,
  parameter int NTAPS  = 6
) (
  input logic      clk,
  input logic      rst_n,
  timebase_if.slave bus
);
  localparam int MS_DIV = CLK_HZ / 1000;
  localparam int PW     = $clog2(MS_DIV);
  localparam logic [PW-1:0] PMAX = PW'(MS_DIV - 1);

  logic [WIDTH-1:0] cnt_q;
  logic [PW-1:0]    pcnt_q;
  logic [NTAPS-1:0] taps_q;
  logic [NTAPS-1:0] hit;
  logic             ms_q;

  // tap i fires when its low bits are all ones, i.e. about to roll to 0
  for (genvar i = 0; i < NTAPS; i++) begin : g_tap
    localparam int TB = (i * (WIDTH - 1)) / (NTAPS - 1);
    assign hit[i] = &cnt_q[TB:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      pcnt_q <= '0;
      taps_q <= '0;
      ms_q   <= 1'b0;
    end else if (bus.clr) begin
      cnt_q  <= '0;
      pcnt_q <= '0;
      taps_q <= '0;
      ms_q   <= 1'b0;
    end else if (bus.en) begin
      cnt_q  <= cnt_q + WIDTH'(1);
      taps_q <= hit;
      if (pcnt_q == PMAX) begin
        pcnt_q <= '0;
        ms_q   <= 1'b1;
      end else begin
        pcnt_q <= pcnt_q + PW'(1);
        ms_q   <= 1'b0;
      end
    end else begin
      taps_q <= '0;
      ms_q   <= 1'b0;
    end
  end

  assign bus.cnt     = cnt_q;
  assign bus.taps    = taps_q;
  assign bus.ms_tick = ms_q;
endmodule

// File: tb/tb_timebase.sv
// tb_timebase: randomized and directed checks of timebase.
// Two instances (8b/3 taps, 32b/6 taps) against an arithmetic model.
module tb_timebase;
  localparam int HZ     = 12000;
  localparam int MS_DIV = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  timebase_if #(.WIDTH(8), .NTAPS(3)) b8 ();
  timebase_if #(.WIDTH(32), .NTAPS(6)) b32 ();

  timebase #(.CLK_HZ(HZ), .WIDTH(8), .NTAPS(3)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b8)
  );
  timebase #(.CLK_HZ(HZ), .WIDTH(32), .NTAPS(6)) dut32 (
    .clk(clk), .rst_n(rst_n), .bus(b32)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: total enabled increments since last clear/reset
  longint     mc;
  int         mp;
  logic [2:0] et8;
  logic [5:0] et32;
  logic       ems;

  function automatic int tb8(int i);
    return (i * 7) / 2;
  endfunction

  function automatic int tb32(int i);
    return (i * 31) / 5;
  endfunction

  function automatic logic [7:0] m8();
    return 8'(mc % 256);
  endfunction

  function automatic logic [31:0] m32();
    return 32'(mc % (64'd1 << 32));
  endfunction

  task automatic model_clear();
    mc = 0; mp = 0; et8 = '0; et32 = '0; ems = 1'b0;
  endtask

  task automatic cycle(input bit e, input bit c);
    @(negedge clk);
    b8.en = e; b8.clr = c;
    b32.en = e; b32.clr = c;
    @(posedge clk);
    if (c) begin
      model_clear();
    end else if (e) begin
      mc = mc + 1;
      mp = (mp + 1) % MS_DIV;
      ems = (mp == 0);
      for (int i = 0; i < 3; i++)
        et8[i] = ((mc % (64'd1 << (tb8(i) + 1))) == 0);
      for (int i = 0; i < 6; i++)
        et32[i] = ((mc % (64'd1 << (tb32(i) + 1))) == 0);
    end else begin
      et8 = '0; et32 = '0; ems = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    b8.en = 0; b8.clr = 0; b32.en = 0; b32.clr = 0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    b8.en = 1; b8.clr = 0; b32.en = 1; b32.clr = 0;
    @(posedge clk); #1;
    checks++;
    if (b8.cnt !== 8'd0 || b8.taps !== 3'd0 || b8.ms_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset8: cnt=%0h taps=%b ms=%b expected 0/000/0",
               b8.cnt, b8.taps, b8.ms_tick);
    end
    checks++;
    if (b32.cnt !== 32'd0 || b32.taps !== 6'd0 || b32.ms_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset32: cnt=%0h taps=%b ms=%b expected 0",
               b32.cnt, b32.taps, b32.ms_tick);
    end
    do_reset();
    cycle(1, 0);
    checks++;
    if (b8.cnt !== 8'd1) begin
      errors++;
      $display("FAIL first_inc: cnt=%0d expected 1", b8.cnt);
    end
  endtask

  task automatic test_taps8();
    do_reset();
    for (int k = 1; k <= 300; k++) begin
      cycle(1, 0);
      checks++;
      if (b8.cnt !== m8() || b8.taps !== et8) begin
        errors++;
        $display("FAIL taps8 k=%0d: cnt=%0d taps=%b expected %0d/%b",
                 k, b8.cnt, b8.taps, m8(), et8);
      end
      if (k == 256) begin
        checks++;
        if (b8.taps !== 3'b111 || b8.cnt !== 8'd0) begin
          errors++;
          $display("FAIL wrap8: taps=%b cnt=%0d expected 111/0",
                   b8.taps, b8.cnt);
        end
      end
    end
  endtask

  task automatic test_ms_tick();
    int pulses;
    int first;
    pulses = 0;
    first = -1;
    do_reset();
    for (int k = 1; k <= 120; k++) begin
      cycle(1, 0);
      checks++;
      if (b8.ms_tick !== ems) begin
        errors++;
        $display("FAIL ms_tick k=%0d: got %b expected %b", k, b8.ms_tick, ems);
      end
      if (b8.ms_tick === 1'b1) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    checks++;
    if (pulses != 10 || first != 12) begin
      errors++;
      $display("FAIL ms_count: pulses=%0d first=%0d expected 10/12",
               pulses, first);
    end
  endtask

  task automatic test_en_hold();
    do_reset();
    for (int k = 0; k < 13; k++) cycle(1, 0);
    for (int k = 0; k < 5; k++) begin
      cycle(0, 0);
      checks++;
      if (b8.cnt !== 8'd13 || b8.taps !== 3'd0 || b8.ms_tick !== 1'b0) begin
        errors++;
        $display("FAIL en_hold: cnt=%0d taps=%b ms=%b expected 13/000/0",
                 b8.cnt, b8.taps, b8.ms_tick);
      end
    end
    for (int k = 1; k <= 3; k++) begin
      cycle(1, 0);
      checks++;
      if (b8.taps[1] !== (k == 3) || b8.cnt !== 8'(13 + k)) begin
        errors++;
        $display("FAIL en_resume k=%0d: cnt=%0d tap1=%b expected %0d/%b",
                 k, b8.cnt, b8.taps[1], 13 + k, (k == 3));
      end
    end
  endtask

  task automatic test_clr();
    do_reset();
    for (int k = 0; k < 200; k++) cycle(1, 0);
    checks++;
    if (b8.cnt !== 8'd200) begin
      errors++;
      $display("FAIL clr_pre: cnt=%0d expected 200", b8.cnt);
    end
    cycle(1, 1);
    checks++;
    if (b8.cnt !== 8'd0 || b8.taps !== 3'd0 || b8.ms_tick !== 1'b0 ||
        b32.cnt !== 32'd0) begin
      errors++;
      $display("FAIL clr: cnt=%0d taps=%b ms=%b cnt32=%0d expected 0",
               b8.cnt, b8.taps, b8.ms_tick, b32.cnt);
    end
    for (int k = 1; k <= 256; k++) begin
      cycle(1, 0);
      checks++;
      if (b8.taps[2] !== (k == 256) || b8.taps !== et8 ||
          b8.ms_tick !== ems) begin
        errors++;
        $display("FAIL clr_after k=%0d: taps=%b ms=%b expected %b/%b",
                 k, b8.taps, b8.ms_tick, et8, ems);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 0; k < 77; k++) cycle(1, 0);
    checks++;
    if (b8.cnt !== 8'd77 || mp != 5) begin
      errors++;
      $display("FAIL arst_pre: cnt=%0d mp=%0d expected 77/5", b8.cnt, mp);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (b8.cnt !== 8'd0 || b8.taps !== 3'd0 || b8.ms_tick !== 1'b0 ||
        b32.cnt !== 32'd0) begin
      errors++;
      $display("FAIL arst: cnt=%0d taps=%b ms=%b expected immediate 0",
               b8.cnt, b8.taps, b8.ms_tick);
    end
    do_reset();
    for (int k = 1; k <= 300; k++) begin
      cycle(1, 0);
      checks++;
      if (b8.cnt !== m8() || b8.taps !== et8 || b8.ms_tick !== ems) begin
        errors++;
        $display("FAIL arst_replay k=%0d: cnt=%0d taps=%b ms=%b exp %0d/%b/%b",
                 k, b8.cnt, b8.taps, b8.ms_tick, m8(), et8, ems);
      end
    end
  endtask

  task automatic test_random();
    bit e;
    bit c;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      e = ($urandom_range(0, 9) != 0);
      c = ($urandom_range(0, 49) == 0);
      cycle(e, c);
      checks++;
      if (b8.cnt !== m8() || b8.taps !== et8 || b8.ms_tick !== ems ||
          b32.cnt !== m32() || b32.taps !== et32 || b32.ms_tick !== ems) begin
        errors++;
        $display("FAIL random k=%0d: c8=%0d t8=%b c32=%0d t32=%b ms=%b exp %0d/%b/%0d/%b/%b",
                 k, b8.cnt, b8.taps, b32.cnt, b32.taps, b8.ms_tick,
                 m8(), et8, m32(), et32, ems);
      end
    end
  endtask

  task automatic test_sweep32();
    logic [31:0] pv;
    logic [31:0] cv;
    logic [5:0]  ex;
    do_reset();
    pv = '0;
    for (int k = 1; k <= 9000; k++) begin
      cycle(1, 0);
      cv = m32();
      for (int i = 0; i < 6; i++)
        ex[i] = pv[tb32(i)] & ~cv[tb32(i)];
      pv = cv;
      checks++;
      if (b32.taps !== ex || b32.cnt !== cv) begin
        errors++;
        $display("FAIL sweep32 k=%0d: cnt=%0d taps=%b expected %0d/%b",
                 k, b32.cnt, b32.taps, cv, ex);
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_taps8();
    test_ms_tick();
    test_en_hold();
    test_clr();
    test_async_reset();
    test_random();
    test_sweep32();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
